// File: rtl/egress_sched_pkg.sv
// Shared definitions for the egress scheduler: parameter defaults and FSM state type.
package egress_sched_pkg;

    localparam int NUM_PORTS_DEF      = 4;
    localparam int LEN_WIDTH_DEF      = 6;  // width of the metadata len field
    localparam int TIMEOUT_CYCLES_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } egress_sched_state_e;

endpackage

// File: rtl/egress_sched_if.sv
// Request/grant bundle between ingress queues, the scheduler and the egress buffer.
interface egress_sched_if
    import egress_sched_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) ();
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]           req;
    logic [NUM_PORTS*LEN_WIDTH-1:0] req_len;
    logic                           beat_valid;
    logic                           egress_ready;

    logic [NUM_PORTS-1:0]           grant;
    logic [PW-1:0]                  grant_id;
    logic                           grant_valid;
    logic                           xfer_en;
    logic [LEN_WIDTH-1:0]           beats_left;
    logic                           pkt_done;
    logic                           abort;

    modport master (
        output req, req_len, beat_valid, egress_ready,
        input  grant, grant_id, grant_valid, xfer_en, beats_left, pkt_done, abort
    );

    modport slave (
        input  req, req_len, beat_valid, egress_ready,
        output grant, grant_id, grant_valid, xfer_en, beats_left, pkt_done, abort
    );

endinterface

// File: rtl/egress_sched_rr_arbiter.sv
// Combinational rotating-priority select: first eligible index at or after rr_ptr, with wrap.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible_i,
    input  logic [PW-1:0]        rr_ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PW-1:0]        grant_id_o,
    output logic                 any_o
);

    logic [PW-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        idx        = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        // Walk offsets from farthest to nearest so the nearest eligible index is the last one kept.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = rr_ptr_i + PW'(k);
            if (eligible_i[idx]) begin
                grant_id_o = idx;
                any_o      = 1'b1;
            end
        end
    end

    assign grant_o = NUM_PORTS'(any_o) << grant_id_o;

endmodule

// File: rtl/egress_sched.sv
// Round-robin egress write-path scheduler: per-packet grant, backpressure gating and stall watchdog.
module egress_sched
    import egress_sched_pkg::*;
#(
    parameter int NUM_PORTS      = NUM_PORTS_DEF,
    parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic           clk,
    input logic           reset,
    egress_sched_if.slave bus
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int SW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT_CYCLES - 1);

    egress_sched_state_e  state_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [PW-1:0]        grant_id_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [LEN_WIDTH-1:0] beats_left_q;
    logic [SW-1:0]        stall_cnt_q;
    logic                 pkt_done_q;
    logic                 abort_q;

    logic [LEN_WIDTH-1:0] lens [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [PW-1:0]        arb_id;
    logic                 arb_any;

    logic xfer_en;
    logic stall;
    logic last_beat;
    logic timeout;

    // Zero-length requests are masked so they can never win a grant.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            lens[i]     = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
            eligible[i] = bus.req[i] && (lens[i] != '0);
        end
    end

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .grant_o    (arb_grant),
        .grant_id_o (arb_id),
        .any_o      (arb_any)
    );

    assign xfer_en   = (state_q == ST_XFER) && bus.beat_valid && bus.egress_ready;
    assign stall     = (state_q == ST_XFER) && bus.egress_ready && !bus.beat_valid;
    assign last_beat = xfer_en && (beats_left_q == LEN_WIDTH'(1));
    assign timeout   = stall && (stall_cnt_q == STALL_LIMIT);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
            stall_cnt_q  <= '0;
            pkt_done_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q      <= ST_XFER;
                        grant_q      <= arb_grant;
                        grant_id_q   <= arb_id;
                        beats_left_q <= lens[arb_id];
                        stall_cnt_q  <= '0;
                    end
                end
                ST_XFER: begin
                    if (last_beat || timeout) begin
                        state_q      <= ST_GAP;
                        grant_q      <= '0;
                        grant_id_q   <= '0;
                        beats_left_q <= '0;
                        stall_cnt_q  <= '0;
                        rr_ptr_q     <= grant_id_q + PW'(1);
                        pkt_done_q   <= last_beat;
                        abort_q      <= timeout;
                    end else if (xfer_en) begin
                        if (beats_left_q != '0) begin
                            beats_left_q <= beats_left_q - LEN_WIDTH'(1);
                        end
                        stall_cnt_q <= '0;
                    end else if (stall) begin
                        stall_cnt_q <= stall_cnt_q + SW'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = (state_q == ST_XFER);
    assign bus.xfer_en     = xfer_en;
    assign bus.beats_left  = beats_left_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.abort       = abort_q;

endmodule

// File: tb/tb_egress_sched.sv
// Bench for egress_sched: directed scenarios plus random traffic against a packet-level reference model.
module tb_egress_sched;

    localparam int N  = 4;
    localparam int LW = 6;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    egress_sched_if #(.NUM_PORTS(N), .LEN_WIDTH(LW)) bus ();

    egress_sched #(.NUM_PORTS(N), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus shadow
    logic [N-1:0] req_v;
    int           len_a [N];
    logic         bv;
    logic         er;

    // Reference model: owner = port holding the grant (-1 when none)
    int owner;
    int left;
    int stalls;
    int ptr;
    bit gap;
    bit done;
    bit abrt;

    int       grant_seq [$];
    bit       prev_valid;
    logic [N-1:0] exp_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < N; i++) bus.req_len[i*LW +: LW] = LW'(len_a[i]);
        bus.beat_valid   = bv;
        bus.egress_ready = er;
    endtask

    task automatic model_check();
        exp_grant = (owner >= 0) ? N'(1 << owner) : '0;
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("grant_valid", 32'(bus.grant_valid), 32'(owner >= 0));
        if (owner >= 0) check("grant_id", 32'(bus.grant_id), 32'(owner));
        check("xfer_en", 32'(bus.xfer_en), 32'(owner >= 0 && bv && er));
        check("beats_left", 32'(bus.beats_left), 32'(left));
        check("pkt_done", 32'(bus.pkt_done), 32'(done));
        check("abort", 32'(bus.abort), 32'(abrt));
    endtask

    task automatic release_grant();
        ptr   = (owner + 1) % N;
        owner = -1;
        gap   = 1'b1;
    endtask

    task automatic model_update();
        if (reset) begin
            owner = -1; gap = 1'b0; left = 0; stalls = 0; ptr = 0; done = 1'b0; abrt = 1'b0;
            return;
        end
        done = 1'b0;
        abrt = 1'b0;
        if (gap) begin
            gap = 1'b0;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int p = (ptr + k) % N;
                if (req_v[p] && len_a[p] != 0) begin
                    owner  = p;
                    left   = len_a[p];
                    stalls = 0;
                    break;
                end
            end
        end else if (bv && er) begin
            left--;
            stalls = 0;
            if (left == 0) begin
                done = 1'b1;
                release_grant();
            end
        end else if (er) begin
            stalls++;
            if (stalls == TO) begin
                abrt = 1'b1;
                left = 0;
                release_grant();
            end
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model across the edge.
    task automatic step();
        drive();
        #1;
        model_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        req_v = '0;
        for (int i = 0; i < N; i++) len_a[i] = 0;
        bv = 1'b0;
        er = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        drive();
        owner = -1; gap = 1'b0; left = 0; stalls = 0; ptr = 0; done = 1'b0; abrt = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single packet: port 2, three blocks, no backpressure
        req_v = 4'b0100; len_a[2] = 3; bv = 1'b1; er = 1'b1;
        step();
        req_v = '0;
        for (int c = 1; c <= 3; c++) begin
            settle();
            check("s1_grant", 32'(bus.grant), 32'h4);
            check("s1_beats_left", 32'(bus.beats_left), 32'(4 - c));
            check("s1_xfer_en", 32'(bus.xfer_en), 32'h1);
            step();
        end
        settle();
        check("s1_pkt_done", 32'(bus.pkt_done), 32'h1);
        check("s1_gap_grant", 32'(bus.grant), 32'h0);
        step();
        step();

        // All four ports, length 1, continuous: rotation 0,1,2,3,0
        reset_pulse();
        clear_inputs();
        req_v = 4'b1111;
        for (int i = 0; i < N; i++) len_a[i] = 1;
        bv = 1'b1; er = 1'b1;
        prev_valid = 1'b0;
        grant_seq.delete();
        for (int c = 0; c < 16; c++) begin
            settle();
            if (bus.grant_valid === 1'b1 && !prev_valid) grant_seq.push_back(int'(bus.grant_id));
            prev_valid = (bus.grant_valid === 1'b1);
            step();
        end
        check("s2_grant_count", 32'(grant_seq.size()), 32'd5);
        for (int i = 0; i < grant_seq.size() && i < 5; i++)
            check("s2_grant_order", 32'(grant_seq[i]), 32'(i % N));

        // Backpressure after the 2nd beat of a 4-block packet on port 1
        reset_pulse();
        clear_inputs();
        req_v = 4'b0010; len_a[1] = 4; bv = 1'b1; er = 1'b1;
        step();
        req_v = '0;
        step();
        step();
        er = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("s3_hold_beats", 32'(bus.beats_left), 32'd2);
            check("s3_hold_xfer", 32'(bus.xfer_en), 32'h0);
            step();
        end
        er = 1'b1;
        step();
        step();
        settle();
        check("s3_pkt_done", 32'(bus.pkt_done), 32'h1);
        check("s3_no_abort", 32'(bus.abort), 32'h0);
        step();

        // Watchdog: port 1 never presents a beat, port 2 waits behind it
        reset_pulse();
        clear_inputs();
        req_v = 4'b0010; len_a[1] = 4; bv = 1'b0; er = 1'b1;
        step();
        req_v = 4'b0100; len_a[2] = 2;
        for (int c = 1; c <= TO; c++) begin
            settle();
            check("s4_no_early_abort", 32'(bus.abort), 32'h0);
            step();
        end
        settle();
        check("s4_abort", 32'(bus.abort), 32'h1);
        check("s4_no_done", 32'(bus.pkt_done), 32'h0);
        check("s4_abort_grant", 32'(bus.grant), 32'h0);
        step();
        step();
        settle();
        check("s4_next_grant", 32'(bus.grant), 32'h4);
        req_v = '0; bv = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // Zero-length port 0 is skipped in favour of port 3
        reset_pulse();
        clear_inputs();
        req_v = 4'b1001; len_a[0] = 0; len_a[3] = 2; bv = 1'b1; er = 1'b1;
        step();
        settle();
        check("s5_grant", 32'(bus.grant), 32'h8);
        for (int c = 0; c < 8; c++) begin
            settle();
            check("s5_port0_never", 32'(bus.grant[0]), 32'h0);
            step();
        end

        // Reset in the middle of a 5-block packet
        reset_pulse();
        clear_inputs();
        req_v = 4'b0100; len_a[2] = 5; bv = 1'b1; er = 1'b1;
        step();
        req_v = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_v = 4'b0011; len_a[0] = 2; len_a[1] = 2;
        settle();
        check("s6_grant", 32'(bus.grant), 32'h0);
        check("s6_valid", 32'(bus.grant_valid), 32'h0);
        check("s6_beats", 32'(bus.beats_left), 32'h0);
        check("s6_xfer", 32'(bus.xfer_en), 32'h0);
        check("s6_done", 32'(bus.pkt_done), 32'h0);
        check("s6_abort", 32'(bus.abort), 32'h0);
        step();
        settle();
        check("s6_first_grant", 32'(bus.grant), 32'h1);
        req_v = '0;
        for (int c = 0; c < 8; c++) step();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req_v = N'($urandom);
                for (int i = 0; i < N; i++) len_a[i] = int'($urandom_range(0, 5));
            end
            bv = ($urandom_range(0, 9) < 7);
            er = ($urandom_range(0, 9) < 8);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
